// File: rtl/pbit_output_sampler.sv
// rtl/pbit_output_sampler.sv - settle, periodically sample and majority-vote the 8 output P-bits
module pbit_output_sampler #(
   parameter int NUM_PBITS       = 32,
   parameter int OUT_BASE        = NUM_PBITS - 16,
   parameter int SETTLE_CYCLES   = 64,
   parameter int SAMPLE_INTERVAL = 4,
   parameter int NUM_SAMPLES     = 256,
   parameter int CNT_W           = $clog2(NUM_SAMPLES + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 abort,
   input  logic [0:NUM_PBITS-1] m,
   output logic                 busy,
   output logic                 sample_strobe,
   output logic [CNT_W-1:0]     sample_cnt,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [0:7]           out_word,
   output logic [0:8*CNT_W-1]   ones_count,
   output logic                 done
);

   localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int INT_W = (SAMPLE_INTERVAL > 1) ? $clog2(SAMPLE_INTERVAL) : 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETTLE = 2'd1;
   localparam logic [1:0] S_SAMPLE = 2'd2;
   localparam logic [1:0] S_REPORT = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [SET_W-1:0] settle_q, settle_d;
   logic [INT_W-1:0] intv_q, intv_d;
   logic [CNT_W-1:0] scnt_q, scnt_d;
   logic [CNT_W-1:0] cnt_q [8];
   logic [CNT_W-1:0] cnt_d [8];
   logic [0:7]       word_q, word_d;
   logic             strobe_q, strobe_d;
   logic             done_q, done_d;
   logic             busy_q, valid_q;

   // Only the eight output P-bits are observed; the rest of the state vector is ignored.
   logic unused_m;
   assign unused_m = ^m;

   // Next-state logic: run sequencing, sample capture and the majority vote on the final capture.
   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      intv_d   = intv_q;
      scnt_d   = scnt_q;
      cnt_d    = cnt_q;
      word_d   = word_q;
      strobe_d = 1'b0;
      done_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_SETTLE;
               settle_d = '0;
               intv_d   = '0;
               scnt_d   = '0;
               for (int i = 0; i < 8; i++) cnt_d[i] = '0;
            end
         end
         S_SETTLE: begin
            if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
               state_d = S_SAMPLE;
               intv_d  = '0;
            end else begin
               settle_d = settle_q + 1'b1;
            end
         end
         S_SAMPLE: begin
            if (intv_q == INT_W'(SAMPLE_INTERVAL - 1)) begin
               intv_d   = '0;
               strobe_d = 1'b1;
               scnt_d   = scnt_q + 1'b1;
               for (int i = 0; i < 8; i++)
                  cnt_d[i] = cnt_q[i] + CNT_W'(m[OUT_BASE + i]);
               if (scnt_q == CNT_W'(NUM_SAMPLES - 1)) begin
                  state_d = S_REPORT;
                  // Strict majority: a tie votes 0.
                  for (int i = 0; i < 8; i++)
                     word_d[i] = ((2 * int'(cnt_d[i])) > NUM_SAMPLES);
               end
            end else begin
               intv_d = intv_q + 1'b1;
            end
         end
         default: begin
            if (out_ready) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
      endcase
      // Abort wins over everything but leaves the counters and last result untouched.
      if (abort) begin
         state_d  = S_IDLE;
         settle_d = settle_q;
         intv_d   = intv_q;
         scnt_d   = scnt_q;
         cnt_d    = cnt_q;
         word_d   = word_q;
         strobe_d = 1'b0;
         done_d   = 1'b0;
      end
   end

   // State and output registers; status flags are registered from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         settle_q <= '0;
         intv_q   <= '0;
         scnt_q   <= '0;
         for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
         word_q   <= '0;
         strobe_q <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         intv_q   <= intv_d;
         scnt_q   <= scnt_d;
         cnt_q    <= cnt_d;
         word_q   <= word_d;
         strobe_q <= strobe_d;
         done_q   <= done_d;
         busy_q   <= (state_d != S_IDLE);
         valid_q  <= (state_d == S_REPORT);
      end
   end

   assign busy          = busy_q;
   assign sample_strobe = strobe_q;
   assign sample_cnt    = scnt_q;
   assign out_valid     = valid_q;
   assign out_word      = word_q;
   assign done          = done_q;

   for (genvar g = 0; g < 8; g++) begin : g_cnt
      assign ones_count[g*CNT_W +: CNT_W] = cnt_q[g];
   end

endmodule

// File: tb/tb_pbit_output_sampler.sv
// tb/tb_pbit_output_sampler.sv - randomized self-checking bench for pbit_output_sampler
module tb_pbit_output_sampler;

   localparam int NB    = 24;
   localparam int OB    = NB - 16;
   localparam int SC    = 4;
   localparam int SI    = 2;
   localparam int NS    = 8;
   localparam int CW    = 4;
   localparam int TOTAL = SC + SI * NS;

   typedef logic [7:0] tbl_t [NS];

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic            abort = 1'b0;
   logic [0:NB-1]   m = '0;
   logic            busy;
   logic            sample_strobe;
   logic [CW-1:0]   sample_cnt;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [0:7]      out_word;
   logic [0:8*CW-1] ones_count;
   logic            done;

   int checks = 0;
   int errors = 0;
   logic [0:7] last_word = '0;

   pbit_output_sampler #(
      .NUM_PBITS(NB), .OUT_BASE(OB), .SETTLE_CYCLES(SC),
      .SAMPLE_INTERVAL(SI), .NUM_SAMPLES(NS), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .m(m),
      .busy(busy), .sample_strobe(sample_strobe), .sample_cnt(sample_cnt),
      .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
      .ones_count(ones_count), .done(done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: ones per output bit and strict-majority word from the sample table.
   function automatic int ref_ones(input tbl_t tbl, input int b);
      int s = 0;
      for (int j = 0; j < NS; j++) s += int'(tbl[j][b]);
      return s;
   endfunction

   function automatic logic [0:7] ref_word(input tbl_t tbl);
      logic [0:7] w;
      for (int b = 0; b < 8; b++) w[b] = (2 * ref_ones(tbl, b) > NS);
      return w;
   endfunction

   function automatic tbl_t rand_tbl();
      tbl_t t;
      for (int j = 0; j < NS; j++) t[j] = 8'($urandom);
      return t;
   endfunction

   // Scenario driver: start a run, feed tbl[j] on capture j (noise otherwise), check timing and result.
   task automatic run_samples(input tbl_t tbl, input int abort_edge, input int start_edge);
      int  ncap;
      bit  cap;
      logic [0:7] ew;
      start = 1'b1;
      m = NB'($urandom);
      step();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL run_start busy=%b valid=%b expected busy=1 valid=0", busy, out_valid);
      end
      ncap = 0;
      for (int t = 1; t <= TOTAL; t++) begin
         cap = (t >= SC + SI) && ((t - SC) % SI == 0);
         m = NB'($urandom);
         if (cap) for (int b = 0; b < 8; b++) m[OB + b] = tbl[ncap][b];
         abort = (t == abort_edge);
         start = (t == start_edge);
         step();
         abort = 1'b0;
         start = 1'b0;
         if (t == abort_edge) begin
            checks++;
            if (busy !== 1'b0 || out_valid !== 1'b0 || sample_strobe !== 1'b0) begin
               errors++;
               $display("FAIL abort_exit busy=%b valid=%b strobe=%b expected all 0",
                        busy, out_valid, sample_strobe);
            end
            return;
         end
         if (cap) ncap++;
         checks++;
         if (sample_strobe !== cap) begin
            errors++;
            $display("FAIL strobe t=%0d got %b expected %b", t, sample_strobe, cap);
         end
         checks++;
         if (sample_cnt !== CW'(ncap)) begin
            errors++;
            $display("FAIL sample_cnt t=%0d got %0d expected %0d", t, sample_cnt, ncap);
         end
         checks++;
         if (out_valid !== (t == TOTAL) || busy !== 1'b1) begin
            errors++;
            $display("FAIL run_status t=%0d valid=%b busy=%b expected valid=%b busy=1",
                     t, out_valid, busy, (t == TOTAL));
         end
      end
      ew = ref_word(tbl);
      checks++;
      if (out_word !== ew) begin
         errors++;
         $display("FAIL out_word got %b expected %b", out_word, ew);
      end
      for (int b = 0; b < 8; b++) begin
         checks++;
         if (ones_count[b*CW +: CW] !== CW'(ref_ones(tbl, b))) begin
            errors++;
            $display("FAIL ones_count[%0d] got %0d expected %0d",
                     b, ones_count[b*CW +: CW], ref_ones(tbl, b));
         end
      end
      last_word = ew;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      checks++;
      if (busy !== 1'b0 || sample_strobe !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 ||
          out_word !== 8'h00 || ones_count !== '0 || sample_cnt !== '0) begin
         errors++;
         $display("FAIL reset_state busy=%b strobe=%b valid=%b done=%b word=%b cnt=%0d ones=%h expected all 0",
                  busy, sample_strobe, out_valid, done, out_word, sample_cnt, ones_count);
      end
      rst_n = 1'b1;
      step();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle busy=%b expected 0", busy);
      end
   endtask

   task automatic test_fixed_pattern();
      tbl_t t;
      for (int j = 0; j < NS; j++) t[j] = 8'b1010_0101;
      run_samples(t, -1, -1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checks++;
      if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL fixed_handshake done=%b valid=%b busy=%b expected 1/0/0", done, out_valid, busy);
      end
      step();
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL fixed_done_pulse done=%b expected 0", done);
      end
   endtask

   task automatic test_tie();
      tbl_t t;
      t = rand_tbl();
      for (int j = 0; j < NS; j++) begin
         t[j][0] = (j % 2 == 0);
         t[j][1] = (j < 5);
      end
      run_samples(t, -1, -1);
      checks++;
      if (out_word[0] !== 1'b0 || out_word[1] !== 1'b1) begin
         errors++;
         $display("FAIL tie_vote word[0]=%b word[1]=%b expected 0/1", out_word[0], out_word[1]);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_hold_ready();
      tbl_t t;
      logic [0:7] ew;
      t  = rand_tbl();
      ew = ref_word(t);
      run_samples(t, -1, -1);
      for (int k = 0; k < 10; k++) begin
         step();
         checks++;
         if (out_valid !== 1'b1 || out_word !== ew || sample_cnt !== CW'(NS) || done !== 1'b0) begin
            errors++;
            $display("FAIL hold_stable k=%0d valid=%b word=%b cnt=%0d done=%b expected 1/%b/%0d/0",
                     k, out_valid, out_word, sample_cnt, done, ew, NS);
         end
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL hold_accept done=%b busy=%b valid=%b expected 1/0/0", done, busy, out_valid);
      end
      step();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL hold_after done=%b busy=%b expected 0/0", done, busy);
      end
   endtask

   task automatic test_start_ignored();
      out_ready = 1'b1;
      run_samples(rand_tbl(), -1, SC + SI * 3 + 1);
      start = 1'b1;
      step();
      start = 1'b0;
      out_ready = 1'b0;
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL start_hs done=%b busy=%b valid=%b expected 1/0/0", done, busy, out_valid);
      end
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored k=%0d busy=%b done=%b expected 0/0", k, busy, done);
         end
      end
   endtask

   task automatic test_abort();
      out_ready = 1'b1;
      run_samples(rand_tbl(), SC + SI * 3, -1);
      for (int k = 0; k < 5; k++) begin
         step();
         checks++;
         if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle k=%0d busy=%b valid=%b done=%b expected 0/0/0",
                     k, busy, out_valid, done);
         end
      end
      out_ready = 1'b0;
      run_samples(rand_tbl(), -1, -1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL abort_rerun_done done=%b expected 1", done);
      end
   endtask

   task automatic test_async_reset();
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      checks++;
      if (busy !== 1'b1 || out_word !== last_word || sample_cnt !== '0 || ones_count !== '0) begin
         errors++;
         $display("FAIL settle_state busy=%b word=%b cnt=%0d ones=%h expected 1/%b/0/0",
                  busy, out_word, sample_cnt, ones_count, last_word);
      end
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || sample_strobe !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 ||
          out_word !== 8'h00 || ones_count !== '0 || sample_cnt !== '0) begin
         errors++;
         $display("FAIL async_reset busy=%b strobe=%b valid=%b done=%b word=%b cnt=%0d expected all 0",
                  busy, sample_strobe, out_valid, done, out_word, sample_cnt);
      end
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step();
         checks++;
         if (busy !== 1'b0 || sample_strobe !== 1'b0) begin
            errors++;
            $display("FAIL reset_wait k=%0d busy=%b strobe=%b expected 0/0", k, busy, sample_strobe);
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int r = 0; r < 3; r++) begin
         run_samples(rand_tbl(), -1, -1);
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
         checks++;
         if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done r=%0d done=%b busy=%b expected 1/0", r, done, busy);
         end
      end
   endtask

   initial begin
      test_reset();
      test_fixed_pattern();
      test_tie();
      test_hold_ready();
      test_start_ignored();
      test_abort();
      test_async_reset();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
